pipe_regs_fde: RTL

- Fetch/decode/execute pipeline register bank; the consumer of the hazard unit's stallF, stallD and flushE outputs.
- Holds the PC, the F/D register and the D/E register, and applies hold, clear and load priority per stage.
- Tracks a per-stage valid bit and keeps saturating stall and bubble performance counters.
- Sits between the fetch datapath, the decode datapath and the ALU stage of the 5-stage core.

---
 rtl/pipe_regs_fde.sv | 112 +++++++++++
 1 files changed

// File: rtl/pipe_regs_fde.sv
// Fetch/decode/execute pipeline register bank.
// Holds the PC, the F/D and D/E registers, per-stage valid bits and
// saturating stall/bubble performance counters. All outputs are registered.
module pipe_regs_fde #(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 10,
  parameter logic [DATA_W-1:0]  RESET_PC = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushE,
  input  logic              pcsrcD,
  input  logic [DATA_W-1:0] pcnextF,
  input  logic [31:0]       instrF,
  input  logic [DATA_W-1:0] pcplus4F,
  output logic [DATA_W-1:0] pcF,
  output logic [31:0]       instrD,
  output logic [DATA_W-1:0] pcplus4D,
  output logic              validD,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic [DATA_W-1:0] rd1D,
  input  logic [DATA_W-1:0] rd2D,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic [4:0]        rdD,
  input  logic [DATA_W-1:0] signimmD,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [DATA_W-1:0] srcaE,
  output logic [DATA_W-1:0] srcbE,
  output logic [4:0]        rsE,
  output logic [4:0]        rtE,
  output logic [4:0]        rdE,
  output logic [DATA_W-1:0] signimmE,
  output logic              validE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // PC register: hold on stallF, otherwise advance to the next PC
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcF <= RESET_PC;
    end else if (!stallF) begin
      pcF <= pcnextF;
    end
  end

  // F/D register: stall holds (even over a taken branch, which re-resolves
  // next cycle), a taken branch squashes F into a nop, otherwise load
  always_ff @(posedge clk) begin
    if (!reset) begin
      instrD   <= '0;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else if (stallD) begin
      instrD   <= instrD;
      pcplus4D <= pcplus4D;
      validD   <= validD;
    end else if (pcsrcD) begin
      instrD   <= '0;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else begin
      instrD   <= instrF;
      pcplus4D <= pcplus4F;
      validD   <= 1'b1;
    end
  end

  // D/E register: never stalls; a flush inserts a bubble whose register
  // specifiers are all zero so forwarding logic can never match it
  always_ff @(posedge clk) begin
    if (!reset || flushE) begin
      ctrlE    <= '0;
      srcaE    <= '0;
      srcbE    <= '0;
      rsE      <= '0;
      rtE      <= '0;
      rdE      <= '0;
      signimmE <= '0;
      validE   <= 1'b0;
    end else begin
      ctrlE    <= ctrlD;
      srcaE    <= rd1D;
      srcbE    <= rd2D;
      rsE      <= rsD;
      rtE      <= rtD;
      rdE      <= rdD;
      signimmE <= signimmD;
      validE   <= validD;
    end
  end

  // Saturating performance counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stallD && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flushE && (bubble_cnt != {CNT_W{1'b1}})) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule
